// File: rtl/line_window_if.sv
// Row-in / window-out handshake bundle for line_window_buffer.
// Latency: none, wires only.
// Backpressure: valid/ready on both the row side and the window side.
interface line_window_if #(
  parameter int DW = 96,   // one unpadded row
  parameter int WW = 336,  // KH padded rows
  parameter int IW = 2     // output row index
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_window;
  logic [IW-1:0] out_row_idx;
  logic          out_last;

  // Row producer and window consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_window, out_row_idx, out_last
  );

  // Line buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_window, out_row_idx, out_last
  );
endinterface

// File: rtl/line_window_buffer.sv
// KH-row sliding convolution window over a row stream, zero padded on all sides.
// Latency: window valid 1 cycle after the last row it needs is accepted.
// Backpressure: in_ready low while a window is held; window held stable until out_ready.
// Option: LINE_WIN_STRIDE2_EN selects vertical stride 2 (only even output rows).
module line_window_buffer #(
  parameter int DATA_BITS = 8,
  parameter int D         = 1,
  parameter int W         = 12,
  parameter int H         = 3,
  parameter int KH        = 3
) (
  input  logic         clk,
  input  logic         reset,
  line_window_if.slave bus
);

  localparam int PAD  = (KH - 1) / 2;
  localparam int PADW = PAD * D * DATA_BITS;
  localparam int DW   = D * W * DATA_BITS;
  localparam int RB   = D * (W + 2 * PAD) * DATA_BITS;
  localparam int IW   = (H > 1) ? $clog2(H) : 1;
  localparam int RW   = (KH > 1) ? $clog2(KH) : 1;
  localparam int NW   = $clog2(H + KH + 4) + 1;
`ifdef LINE_WIN_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  // Any output row at or beyond this index is the last one of the frame.
  localparam int LAST_R = (H > STRIDE) ? H - STRIDE : 0;

  localparam logic [NW-1:0] LAST_ROW = NW'(H - 1);
  localparam logic [NW-1:0] PAD_ROW  = NW'(PAD);

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_WAIT} state_t;

  state_t          st, st_nxt;
  logic [RB-1:0]   ring [KH];
  logic [RW-1:0]   rd, rd1, rd2;      // rd points at the oldest (top) row
  logic [IW-1:0]   r, r_nxt;          // output row of the current window
  logic [NW-1:0]   nrow, nrow_nxt;    // image row number that loads next
  logic [1:0]      pend, pend_nxt;    // rows still to load before the next window
  logic [1:0]      n_wr;              // ring writes this cycle (0..2)
  logic [RB-1:0]   wr0;               // first write; a second write is always a zero row
  logic            clr;
  logic            last;
  logic            in_ready_c, out_valid_c;
  logic [RB-1:0]   padded;
  logic [KH*RB-1:0] window;

  assign rd1  = (rd  == RW'(KH - 1)) ? '0 : rd  + RW'(1);
  assign rd2  = (rd1 == RW'(KH - 1)) ? '0 : rd1 + RW'(1);
  assign last = (st == S_STREAM) && (r >= IW'(LAST_R));

  // Incoming row with PAD zero pixels on each side.
  always_comb begin
    padded = '0;
    padded[PADW +: DW] = bus.in_data;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) st <= S_FILL;
    else       st <= st_nxt;
  end

  // Next state, handshakes and ring write plan.
  always_comb begin
    st_nxt      = st;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    n_wr        = 2'd0;
    wr0         = '0;
    clr         = 1'b0;
    r_nxt       = r;
    nrow_nxt    = nrow;
    pend_nxt    = pend;
    case (st)
      S_FILL: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          n_wr     = 2'd1;
          wr0      = padded;
          nrow_nxt = nrow + NW'(1);
          if (nrow == PAD_ROW) begin
            st_nxt = S_STREAM;
            r_nxt  = '0;
          end
        end
      end
      S_STREAM: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          if (last) begin
            // Frame done: drop everything so the next frame starts from zeros.
            st_nxt   = S_FILL;
            clr      = 1'b1;
            r_nxt    = '0;
            nrow_nxt = '0;
            pend_nxt = 2'd0;
          end else begin
            r_nxt = r + IW'(STRIDE);
            if (nrow > LAST_ROW) begin
              // Below the image: shift in zero rows without waiting for input.
              n_wr     = 2'(STRIDE);
              nrow_nxt = nrow + NW'(STRIDE);
              pend_nxt = 2'd0;
            end else begin
              st_nxt   = S_WAIT;
              pend_nxt = 2'(STRIDE);
            end
          end
        end
      end
      S_WAIT: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          n_wr     = 2'd1;
          wr0      = padded;
          nrow_nxt = nrow + NW'(1);
          if (pend == 2'd1) begin
            st_nxt   = S_STREAM;
            pend_nxt = 2'd0;
          end else if ((nrow + NW'(1)) > LAST_ROW) begin
            // Second row of a stride-2 step falls below the image.
            n_wr     = 2'd2;
            nrow_nxt = nrow + NW'(2);
            st_nxt   = S_STREAM;
            pend_nxt = 2'd0;
          end else begin
            pend_nxt = 2'd1;
          end
        end
      end
      default: st_nxt = S_FILL;
    endcase
  end

  // Row ring: new rows overwrite the oldest entry and the read pointer follows.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < KH; i++) ring[i] <= '0;
      rd <= '0;
    end else begin
      for (int i = 0; i < KH; i++) begin
        if (n_wr != 2'd0 && RW'(i) == rd)  ring[i] <= wr0;
        if (n_wr == 2'd2 && RW'(i) == rd1) ring[i] <= '0;
      end
      if (n_wr == 2'd2)      rd <= rd2;
      else if (n_wr == 2'd1) rd <= rd1;
    end
  end

  // Row counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r    <= '0;
      nrow <= '0;
      pend <= 2'd0;
    end else begin
      r    <= r_nxt;
      nrow <= nrow_nxt;
      pend <= pend_nxt;
    end
  end

  // Window slice k is the k-th oldest ring row (k=0 top).
  always_comb begin
    int idx;
    idx    = 0;
    window = '0;
    for (int k = 0; k < KH; k++) begin
      idx = (int'(rd) + k) % KH;
      window[k*RB +: RB] = ring[RW'(idx)];
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_window  = window;
  assign bus.out_row_idx = (st == S_STREAM) ? r : '0;
  assign bus.out_last    = last;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: reset, streaming, stalls, back-to-back
// frames and mid-frame reset; with LINE_WIN_STRIDE2_EN, the KH=5 stride-2 case.
module tb_line_window_buffer;

  localparam int DB = 8;
  localparam int D  = 1;
  localparam int W  = 12;
`ifdef LINE_WIN_STRIDE2_EN
  localparam int H  = 5;
  localparam int KH = 5;
`else
  localparam int H  = 3;
  localparam int KH = 3;
`endif
  localparam int PAD  = (KH - 1) / 2;
  localparam int PADW = PAD * D * DB;
  localparam int DW   = D * W * DB;
  localparam int RB   = D * (W + 2 * PAD) * DB;
  localparam int WW   = KH * RB;
  localparam int IW   = (H > 1) ? $clog2(H) : 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   win_cnt = 0;
  int   last_cnt = 0;

  always #5 clk = ~clk;

  line_window_if #(.DW(DW), .WW(WW), .IW(IW)) bus ();

  line_window_buffer #(.DATA_BITS(DB), .D(D), .W(W), .H(H), .KH(KH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk_b(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkrow(input logic [7:0] s);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < D * W; i++) v[i*DB +: DB] = s + 8'(i);
    return v;
  endfunction

  function automatic logic [RB-1:0] pr(input logic [DW-1:0] row);
    return {{PADW{1'b0}}, row, {PADW{1'b0}}};
  endfunction

`ifdef LINE_WIN_STRIDE2_EN
  function automatic logic [WW-1:0] win5(input logic [DW-1:0] a, b, c, d, e);
    return {pr(e), pr(d), pr(c), pr(b), pr(a)};
  endfunction
`else
  function automatic logic [WW-1:0] win3(input logic [DW-1:0] t, m, b);
    return {pr(b), pr(m), pr(t)};
  endfunction
`endif

  task automatic send_row(input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_b("in_ready_timeout", 32'(n < 200), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_b("out_valid_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic get_win(input string tag, input logic [WW-1:0] w, input int idx, input bit lst);
    wait_valid();
    chk_w({tag, "_win"}, bus.out_window, w);
    chk_b({tag, "_idx"}, 32'(bus.out_row_idx), 32'(idx));
    chk_b({tag, "_last"}, 32'(bus.out_last), 32'(lst));
    win_cnt++;
    if (bus.out_last === 1'b1) last_cnt++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk_b({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk_b({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk_w({tag, "_window"}, bus.out_window, '0);
    chk_b({tag, "_idx"}, 32'(bus.out_row_idx), 32'd0);
    chk_b({tag, "_last"}, 32'(bus.out_last), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    logic [DW-1:0] ra, rb, rc, rd, re, rf;
    logic [WW-1:0] w0;
    bit stable;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    ra = mkrow(8'hA0); rb = mkrow(8'hB0); rc = mkrow(8'hC0);
    rd = mkrow(8'hD0); re = mkrow(8'hE0); rf = mkrow(8'h10);

    // Reset held two cycles.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

`ifdef LINE_WIN_STRIDE2_EN
    // KH=5, H=5, stride 2: rows R0..R4 -> windows 0, 2, 4.
    send_row(ra);
    send_row(rb);
    chk_b("s2_fill_no_valid", 32'(bus.out_valid), 32'd0);
    send_row(rc);
    chk_b("s2_first_latency", 32'(bus.out_valid), 32'd1);
    get_win("s2_r0", win5('0, '0, ra, rb, rc), 0, 1'b0);
    send_row(rd);
    chk_b("s2_wait_second_row", 32'(bus.in_ready), 32'd1);
    chk_b("s2_wait_no_valid", 32'(bus.out_valid), 32'd0);
    send_row(re);
    get_win("s2_r2", win5(ra, rb, rc, rd, re), 2, 1'b0);
    get_win("s2_r4", win5(rc, rd, re, '0, '0), 4, 1'b1);
    chk_b("s2_no_odd_window", 32'(bus.out_valid), 32'd0);
    chk_b("s2_refill_ready", 32'(bus.in_ready), 32'd1);
`else
    // Plain frame A,B,C with immediate consumption.
    send_row(ra);
    chk_b("fill_no_valid", 32'(bus.out_valid), 32'd0);
    send_row(rb);
    chk_b("first_latency", 32'(bus.out_valid), 32'd1);
    get_win("f1_r0", win3('0, ra, rb), 0, 1'b0);
    chk_b("wait_in_ready", 32'(bus.in_ready), 32'd1);
    send_row(rc);
    get_win("f1_r1", win3(ra, rb, rc), 1, 1'b0);
    get_win("f1_r2", win3(rb, rc, '0), 2, 1'b1);
    chk_b("f1_end_out_valid", 32'(bus.out_valid), 32'd0);
    chk_b("f1_end_in_ready", 32'(bus.in_ready), 32'd1);

    // Stall: window held while next row is offered.
    send_row(rd);
    send_row(re);
    wait_valid();
    w0 = win3('0, rd, re);
    chk_w("stall_win_before", bus.out_window, w0);
    bus.in_valid = 1'b1;
    bus.in_data  = rf;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_window !== w0)
        stable = 1'b0;
    end
    chk_b("stall_stable", 32'(stable), 32'd1);
    get_win("stall_r0", w0, 0, 1'b0);
    send_row(rf);
    get_win("stall_r1", win3(rd, re, rf), 1, 1'b0);
    get_win("stall_r2", win3(re, rf, '0), 2, 1'b1);

    // Back-to-back frames A,B,C then D,E,F.
    win_cnt = 0;
    last_cnt = 0;
    send_row(ra);
    send_row(rb);
    get_win("b2b_a_r0", win3('0, ra, rb), 0, 1'b0);
    send_row(rc);
    get_win("b2b_a_r1", win3(ra, rb, rc), 1, 1'b0);
    get_win("b2b_a_r2", win3(rb, rc, '0), 2, 1'b1);
    send_row(rd);
    send_row(re);
    get_win("b2b_d_r0", win3('0, rd, re), 0, 1'b0);
    send_row(rf);
    get_win("b2b_d_r1", win3(rd, re, rf), 1, 1'b0);
    get_win("b2b_d_r2", win3(re, rf, '0), 2, 1'b1);
    chk_b("b2b_window_count", 32'(win_cnt), 32'd6);
    chk_b("b2b_last_count", 32'(last_cnt), 32'd2);

    // Mid-frame reset discards partial frame.
    send_row(rf);
    send_row(rc);
    reset = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    reset = 1'b0;
    send_row(rd);
    send_row(ra);
    get_win("post_rst_r0", win3('0, rd, ra), 0, 1'b0);
    send_row(re);
    get_win("post_rst_r1", win3(rd, ra, re), 1, 1'b0);
    get_win("post_rst_r2", win3(ra, re, '0), 2, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
